// File: rtl/ratio_ctrl_pkg.sv
// Shared constants and FSM state encoding for the multi-channel ratio controller.
// Results are fixed-point with a two-digit decimal fraction held in DEC_W bits.
package ratio_ctrl_pkg;

    localparam int SCALE   = 100;
    localparam int DEC_W   = 7;
    localparam int DEC_MAX = 99;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        DIV1,
        DIV2,
        STORE,
        DONE
    } state_t;

endpackage

// File: rtl/ratio_seq_divider.sv
// Iterative restoring divider, one quotient bit per enabled cycle, W cycles per division.
// The start cycle already performs the first step, so o_done marks the edge that completes the last bit.
module ratio_seq_divider #(
    parameter int W = 39
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_en,
    input  logic         i_start,
    input  logic [W-1:0] i_dividend,
    input  logic [W-1:0] i_divisor,
    output logic [W-1:0] o_quotient,
    output logic [W-1:0] o_remainder,
    output logic         o_busy,
    output logic         o_done
);

    localparam int CW = $clog2(W + 1);

    logic [W-1:0]  r_quo;
    logic [W-1:0]  r_rem;
    logic [W-1:0]  r_div;
    logic [CW-1:0] r_cnt;
    logic          r_busy;

    logic [W-1:0]  w_src_quo;
    logic [W-1:0]  w_src_rem;
    logic [W-1:0]  w_src_div;
    logic [W-1:0]  w_quo_next;
    logic [W-1:0]  w_rem_next;
    logic [W:0]    w_trial;
    logic [W:0]    w_diff;
    logic          w_ge;
    logic          w_unused_msb;

    always_comb begin
        w_src_quo  = i_start ? i_dividend : r_quo;
        w_src_rem  = i_start ? '0 : r_rem;
        w_src_div  = i_start ? i_divisor : r_div;
        w_trial    = {w_src_rem, w_src_quo[W-1]};
        w_diff     = w_trial - {1'b0, w_src_div};
        w_ge       = (w_trial >= {1'b0, w_src_div});
        w_rem_next = w_ge ? w_diff[W-1:0] : w_trial[W-1:0];
        w_quo_next = {w_src_quo[W-2:0], w_ge};
    end

    // A successful subtraction always leaves a remainder below the divisor, so the MSB is zero.
    assign w_unused_msb = w_diff[W];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_quo  <= '0;
            r_rem  <= '0;
            r_div  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
        end else if (i_en && (i_start || r_busy)) begin
            r_quo <= w_quo_next;
            r_rem <= w_rem_next;
            r_div <= w_src_div;
            if (i_start) begin
                r_cnt  <= CW'(W - 1);
                r_busy <= 1'b1;
            end else begin
                r_cnt  <= r_cnt - CW'(1);
                r_busy <= (r_cnt != CW'(1));
            end
        end
    end

    assign o_quotient  = r_quo;
    assign o_remainder = r_rem;
    assign o_busy      = r_busy;
    assign o_done      = r_busy && (r_cnt == CW'(1));

endmodule

// File: rtl/multi_ratio_controller.sv
// Per-channel divide ratio C_Freq / (whole.dec) as {whole, dec} fixed point, one shared divider.
// Define RATIO_ROUND_EN to round the scaled quotient to nearest instead of truncating.
module multi_ratio_controller
    import ratio_ctrl_pkg::*;
#(
    parameter int NUM_CH  = 2,
    parameter int FREQ_W  = 32,
    parameter int WHOLE_W = 9,
    parameter int OUT_W   = 32
) (
    input  logic                            Clk,
    input  logic                            Reset,
    input  logic                            En,
    input  logic                            Start,
    input  logic [NUM_CH*(WHOLE_W+7)-1:0]   C_N,
    input  logic [FREQ_W-1:0]               C_Freq,
    output logic                            Busy,
    output logic                            Done,
    output logic [NUM_CH*OUT_W-1:0]         C_Div,
    output logic [NUM_CH-1:0]               Err,
    output logic [NUM_CH-1:0]               Ovf
);

    localparam int CN_W = WHOLE_W + DEC_W;
    localparam int QW   = FREQ_W + DEC_W;
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [QW-1:0] WHOLE_MAX = QW'((64'd1 << (OUT_W - DEC_W)) - 64'd1);

    state_t                   r_state;
    state_t                   w_state_next;
    logic [CH_W-1:0]          r_ch;
    logic [NUM_CH*CN_W-1:0]   r_cn;
    logic [FREQ_W-1:0]        r_freq;
    logic [CN_W-1:0]          r_d;
    logic [QW-1:0]            r_num;
    logic                     r_inv;
    logic                     r_busy;
    logic                     r_done;

    logic                     w_accept;
    logic [CN_W-1:0]          w_cn_sel;
    logic [WHOLE_W-1:0]       w_whole;
    logic [DEC_W-1:0]         w_dec;
    logic [CN_W-1:0]          w_d;
    logic [QW-1:0]            w_num;
    logic                     w_inv;

    logic                     w_div_start;
    logic [QW-1:0]            w_div_dividend;
    logic [QW-1:0]            w_div_divisor;
    logic [QW-1:0]            w_quo;
    logic [QW-1:0]            w_rem;
    logic                     w_div_busy;
    logic                     w_div_done;

    logic                     w_sat;
    logic [OUT_W-1:0]         w_result;
    logic                     w_unused_rem;

    // Operand preparation for the channel being loaded: D = 100*whole + dec.
    assign w_cn_sel = r_cn[r_ch*CN_W +: CN_W];
    assign w_whole  = w_cn_sel[CN_W-1:DEC_W];
    assign w_dec    = w_cn_sel[DEC_W-1:0];
    assign w_d      = CN_W'(w_whole) * CN_W'(SCALE) + CN_W'(w_dec);
    assign w_inv    = (w_d == '0) || (w_dec > DEC_W'(DEC_MAX));
`ifdef RATIO_ROUND_EN
    assign w_num    = QW'(r_freq) * QW'(SCALE) + QW'(w_d >> 1);
`else
    assign w_num    = QW'(r_freq) * QW'(SCALE);
`endif

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        case (r_state)
            IDLE: begin
                if (Start) begin
                    w_accept     = 1'b1;
                    w_state_next = LOAD;
                end
            end
            LOAD:  w_state_next = DIV1;
            DIV1:  if (w_div_done) w_state_next = DIV2;
            DIV2:  if (w_div_done) w_state_next = STORE;
            STORE: w_state_next = (r_ch == CH_W'(NUM_CH - 1)) ? DONE : LOAD;
            DONE:  w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state <= IDLE;
            r_ch    <= '0;
            r_cn    <= '0;
            r_freq  <= '0;
            r_d     <= '0;
            r_num   <= '0;
            r_inv   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else if (En) begin
            r_state <= w_state_next;
            r_done  <= (r_state == DONE);
            if (w_accept) begin
                r_cn   <= C_N;
                r_freq <= C_Freq;
                r_ch   <= '0;
                r_busy <= 1'b1;
            end
            if (r_state == DONE) begin
                r_busy <= 1'b0;
            end
            if (r_state == LOAD) begin
                r_d   <= w_d;
                r_num <= w_num;
                r_inv <= w_inv;
            end
            if (r_state == STORE) begin
                r_ch <= r_ch + CH_W'(1);
            end
        end
    end

    // The divider restarts on the first cycle of each division phase; DIV2 reuses DIV1's quotient.
    assign w_div_start    = ((r_state == DIV1) || (r_state == DIV2)) && !w_div_busy;
    assign w_div_dividend = (r_state == DIV2) ? w_quo : r_num;
    assign w_div_divisor  = (r_state == DIV2) ? QW'(SCALE) : QW'(r_d);

    ratio_seq_divider #(
        .W (QW)
    ) u_div (
        .i_clk       (Clk),
        .i_rst       (Reset),
        .i_en        (En),
        .i_start     (w_div_start),
        .i_dividend  (w_div_dividend),
        .i_divisor   (w_div_divisor),
        .o_quotient  (w_quo),
        .o_remainder (w_rem),
        .o_busy      (w_div_busy),
        .o_done      (w_div_done)
    );

    // In STORE the divider holds whole = Q/100 in the quotient and dec = Q%100 in the remainder.
    assign w_sat        = (w_quo > WHOLE_MAX);
    assign w_unused_rem = ^w_rem[QW-1:DEC_W];

    always_comb begin
        w_result = '0;
        if (!r_inv) begin
            if (w_sat) begin
                w_result = {{(OUT_W - DEC_W){1'b1}}, DEC_W'(DEC_MAX)};
            end else begin
                w_result = {w_quo[OUT_W-DEC_W-1:0], w_rem[DEC_W-1:0]};
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [OUT_W-1:0] r_cdiv;
            logic             r_err;
            logic             r_ovf;

            always_ff @(posedge Clk or posedge Reset) begin
                if (Reset) begin
                    r_cdiv <= '0;
                    r_err  <= 1'b0;
                    r_ovf  <= 1'b0;
                end else if (En && (r_state == STORE) && (r_ch == CH_W'(gi))) begin
                    r_cdiv <= w_result;
                    r_err  <= r_inv;
                    r_ovf  <= !r_inv && w_sat;
                end
            end

            assign C_Div[gi*OUT_W +: OUT_W] = r_cdiv;
            assign Err[gi]                  = r_err;
            assign Ovf[gi]                  = r_ovf;
        end
    endgenerate

    assign Busy = r_busy;
    assign Done = r_done;

endmodule

// File: tb/tb_multi_ratio_controller.sv
// Directed bench for multi_ratio_controller: timeline model checked every cycle plus literal expectations.
module tb_multi_ratio_controller;

    localparam int NUM_CH  = 2;
    localparam int FREQ_W  = 32;
    localparam int WHOLE_W = 9;
    localparam int OUT_W   = 32;
    localparam int CN_W    = WHOLE_W + 7;
    localparam int QW      = FREQ_W + 7;
    localparam int PER     = 2 + 2 * QW;
    localparam int TOTAL   = NUM_CH * PER + 1;
    localparam longint unsigned MAXW = (64'd1 << (OUT_W - 7)) - 64'd1;

    logic                       Clk    = 1'b0;
    logic                       Reset  = 1'b1;
    logic                       En     = 1'b1;
    logic                       Start  = 1'b0;
    logic [NUM_CH*CN_W-1:0]     C_N    = '0;
    logic [FREQ_W-1:0]          C_Freq = '0;
    logic                       Busy;
    logic                       Done;
    logic [NUM_CH*OUT_W-1:0]    C_Div;
    logic [NUM_CH-1:0]          Err;
    logic [NUM_CH-1:0]          Ovf;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;
    bit chk_en  = 1'b0;

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    multi_ratio_controller #(
        .NUM_CH  (NUM_CH),
        .FREQ_W  (FREQ_W),
        .WHOLE_W (WHOLE_W),
        .OUT_W   (OUT_W)
    ) dut (
        .Clk    (Clk),
        .Reset  (Reset),
        .En     (En),
        .Start  (Start),
        .C_N    (C_N),
        .C_Freq (C_Freq),
        .Busy   (Busy),
        .Done   (Done),
        .C_Div  (C_Div),
        .Err    (Err),
        .Ovf    (Ovf)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    function automatic logic [CN_W-1:0] mk(input int unsigned whole, input int unsigned dec);
        logic [WHOLE_W-1:0] w;
        logic [6:0]         d;
        w = whole[WHOLE_W-1:0];
        d = dec[6:0];
        return {w, d};
    endfunction

    function automatic logic [OUT_W-1:0] fld(input longint unsigned whole, input longint unsigned dec);
        return OUT_W'(whole * 128 + dec);
    endfunction

    // Specification arithmetic on 64-bit integers: D, scaled quotient Q, then Q/100 and Q%100.
    function automatic bit exp_err(input logic [CN_W-1:0] cn);
        longint unsigned whole = 64'(cn[CN_W-1:7]);
        longint unsigned dec   = 64'(cn[6:0]);
        return (100 * whole + dec == 0) || (dec > 99);
    endfunction

    function automatic longint unsigned exp_q(input logic [CN_W-1:0] cn, input logic [FREQ_W-1:0] freq);
        longint unsigned d   = 100 * 64'(cn[CN_W-1:7]) + 64'(cn[6:0]);
        longint unsigned num = 64'(freq) * 100;
`ifdef RATIO_ROUND_EN
        num = num + d / 2;
`endif
        return num / d;
    endfunction

    function automatic bit exp_ovf(input logic [CN_W-1:0] cn, input logic [FREQ_W-1:0] freq);
        if (exp_err(cn)) return 1'b0;
        return (exp_q(cn, freq) / 100) > MAXW;
    endfunction

    function automatic logic [OUT_W-1:0] exp_field(input logic [CN_W-1:0] cn, input logic [FREQ_W-1:0] freq);
        longint unsigned q;
        if (exp_err(cn)) return '0;
        q = exp_q(cn, freq);
        if (q / 100 > MAXW) return fld(MAXW, 99);
        return fld(q / 100, q % 100);
    endfunction

    // Timeline model: channel i lands PER*(i+1) enabled edges after accept, Done after TOTAL.
    logic                   m_busy;
    logic                   m_done;
    int                     m_k;
    logic [NUM_CH*CN_W-1:0] m_cn;
    logic [FREQ_W-1:0]      m_freq;
    logic [NUM_CH*OUT_W-1:0] m_cdiv;
    logic [NUM_CH-1:0]      m_err;
    logic [NUM_CH-1:0]      m_ovf;

    always @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_k    <= 0;
            m_cn   <= '0;
            m_freq <= '0;
            m_cdiv <= '0;
            m_err  <= '0;
            m_ovf  <= '0;
        end else if (En) begin
            m_done <= 1'b0;
            if (!m_busy) begin
                if (Start) begin
                    m_busy <= 1'b1;
                    m_k    <= 0;
                    m_cn   <= C_N;
                    m_freq <= C_Freq;
                end
            end else begin
                m_k <= m_k + 1;
                for (int i = 0; i < NUM_CH; i++) begin
                    if (m_k + 1 == PER * (i + 1)) begin
                        m_cdiv[i*OUT_W +: OUT_W] <= exp_field(m_cn[i*CN_W +: CN_W], m_freq);
                        m_err[i] <= exp_err(m_cn[i*CN_W +: CN_W]);
                        m_ovf[i] <= exp_ovf(m_cn[i*CN_W +: CN_W], m_freq);
                    end
                end
                if (m_k + 1 == TOTAL) begin
                    m_busy <= 1'b0;
                    m_done <= 1'b1;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge Clk);
            if (chk_en) begin
                check("busy", 64'(Busy), 64'(m_busy));
                check("done", 64'(Done), 64'(m_done));
                check("c_div", 64'(C_Div), 64'(m_cdiv));
                check("err", 64'(Err), 64'(m_err));
                check("ovf", 64'(Ovf), 64'(m_ovf));
            end
        end
    end

    task automatic apply(input logic [CN_W-1:0] c0, input logic [CN_W-1:0] c1,
                         input logic [FREQ_W-1:0] f, output int t_acc);
        @(negedge Clk);
        C_N    = {c1, c0};
        C_Freq = f;
        Start  = 1'b1;
        @(negedge Clk);
        Start  = 1'b0;
        t_acc  = cyc;
        $display("accept at cycle %0d: C_N=0x%0h C_Freq=%0d", t_acc, {c1, c0}, f);
    endtask

    task automatic wait_done(input string name, input int t_acc, input int exp_lat);
        int n = 0;
        while (!Done && n < 1000) begin
            @(negedge Clk);
            n++;
        end
        check(name, 64'(cyc - t_acc), 64'(exp_lat));
        $display("%s: Done after %0d cycles, C_Div=0x%0h Err=%b Ovf=%b", name, cyc - t_acc, C_Div, Err, Ovf);
    endtask

    task automatic check_out(input string name, input logic [OUT_W-1:0] e0, input logic [OUT_W-1:0] e1,
                             input logic [1:0] eerr, input logic [1:0] eovf);
        check({name, "_ch0"}, 64'(C_Div[OUT_W-1:0]), 64'(e0));
        check({name, "_ch1"}, 64'(C_Div[2*OUT_W-1:OUT_W]), 64'(e1));
        check({name, "_err"}, 64'(Err), 64'(eerr));
        check({name, "_ovf"}, 64'(Ovf), 64'(eovf));
    endtask

    logic [OUT_W-1:0] a_ch0;
    logic [OUT_W-1:0] a_ch1;
    int               t;
    int               pulses;

    initial begin
        a_ch0 = fld(2500, 0);
`ifdef RATIO_ROUND_EN
        a_ch1 = fld(1666, 67);
`else
        a_ch1 = fld(1666, 66);
`endif

        repeat (2) @(negedge Clk);
        chk_en = 1'b1;
        @(negedge Clk);
        check("reset_busy", 64'(Busy), 64'd0);
        check("reset_done", 64'(Done), 64'd0);
        check_out("reset", '0, '0, 2'b00, 2'b00);
        Reset = 1'b0;

        // Nominal run; a second Start with other operands mid-run must be ignored.
        apply(mk(2, 0), mk(3, 0), 32'd500000, t);
        repeat (5) @(negedge Clk);
        C_N    = {mk(7, 0), mk(5, 0)};
        C_Freq = 32'd1;
        Start  = 1'b1;
        repeat (5) @(negedge Clk);
        Start  = 1'b0;
        wait_done("nominal_lat", t, 161);
        check_out("nominal", a_ch0, a_ch1, 2'b00, 2'b00);

        // Invalid multipliers: zero and a fraction above 99.
        apply(mk(0, 0), mk(1, 120), 32'd500000, t);
        wait_done("invalid_lat", t, 161);
        check_out("invalid", '0, '0, 2'b11, 2'b00);

        // Tiny multiplier on channel 0 overflows the whole field.
        apply(mk(0, 1), mk(1, 0), 32'd500000000, t);
        wait_done("ovf_lat", t, 161);
        check_out("ovf", fld(33554431, 99), fld(5000000, 0), 2'b00, 2'b01);

        // En low for 20 cycles inside channel 0's first division.
        apply(mk(2, 0), mk(3, 0), 32'd500000, t);
        repeat (10) @(negedge Clk);
        En = 1'b0;
        repeat (20) @(negedge Clk);
        En = 1'b1;
        wait_done("stall_lat", t, 181);
        check_out("stall", a_ch0, a_ch1, 2'b00, 2'b00);

        // Reset during channel 1's second division aborts without Done.
        apply(mk(2, 0), mk(3, 0), 32'd500000, t);
        repeat (140) @(negedge Clk);
        Reset = 1'b1;
        repeat (2) @(negedge Clk);
        check("abort_busy", 64'(Busy), 64'd0);
        check("abort_done", 64'(Done), 64'd0);
        check_out("abort", '0, '0, 2'b00, 2'b00);
        Reset  = 1'b0;
        pulses = 0;
        repeat (60) begin
            @(negedge Clk);
            if (Done) pulses++;
        end
        check("abort_no_done", 64'(pulses), 64'd0);
        $display("abort: %0d Done pulses after reset", pulses);

        apply(mk(2, 0), mk(3, 0), 32'd500000, t);
        wait_done("rerun_lat", t, 161);
        check_out("rerun", a_ch0, a_ch1, 2'b00, 2'b00);

        repeat (3) @(negedge Clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
